// File: rtl/cvxif_mac_unit.sv
// CV-X-IF multiply-accumulate coprocessor.
// Offloaded custom-0 instructions wait in an in-order queue until the core
// commits or kills them. The head entry then runs through an IDLE/EXEC/RESP
// FSM that works on a single accumulator register.
module cvxif_mac_unit #(
    parameter int XLEN        = 64,
    parameter int ID_WIDTH    = 3,
    parameter int QUEUE_DEPTH = 4,
    parameter int MUL_LATENCY = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [31:0]         issue_instr_i,
    input  logic [ID_WIDTH-1:0] issue_id_i,
    input  logic [XLEN-1:0]     issue_rs1_i,
    input  logic [XLEN-1:0]     issue_rs2_i,
    input  logic [1:0]          issue_rs_valid_i,
    output logic                issue_accept_o,
    output logic                issue_writeback_o,
    input  logic                commit_valid_i,
    input  logic [ID_WIDTH-1:0] commit_id_i,
    input  logic                commit_kill_i,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [ID_WIDTH-1:0] result_id_o,
    output logic [XLEN-1:0]     result_data_o,
    output logic [4:0]          result_rd_o,
    output logic                result_we_o,
    output logic                busy_o,
    output logic                err_o
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CYC_W = $clog2(MUL_LATENCY + 1);

    localparam logic [1:0] OP_MAC   = 2'b00;
    localparam logic [1:0] OP_CLR   = 2'b01;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

    // Multiply-accumulate with an unsigned product truncated to XLEN; the
    // sum wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] mac_fn(input logic [XLEN-1:0] acc,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
        logic [XLEN-1:0] prod;
        prod = a * b;
        return acc + prod;
    endfunction

    // Queue storage (data, not reset) and control
    logic [ID_WIDTH-1:0] q_id_q   [QUEUE_DEPTH];
    logic [1:0]          q_op_q   [QUEUE_DEPTH];
    logic [4:0]          q_rd_q   [QUEUE_DEPTH];
    logic [XLEN-1:0]     q_rs1_q  [QUEUE_DEPTH];
    logic [XLEN-1:0]     q_rs2_q  [QUEUE_DEPTH];
    logic                q_kill_q [QUEUE_DEPTH];

    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] ccnt_q, ccnt_d;
    logic             err_q;

    state_e           state_q, state_d;
    logic [CYC_W-1:0] cnt_q;
    logic [XLEN-1:0]  acc_q, acc_next, res_val;
    logic [ID_WIDTH-1:0] res_id_q;
    logic [XLEN-1:0]  res_data_q;
    logic [4:0]       res_rd_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       supported, is_mac, ops_ok, full, push, pop;
    logic [PTR_W-1:0] cmt_idx;
    logic       cmt_avail, cmt_ok, cmt_bad;
    logic       head_committed, head_killed, exec_fire;
    logic       unused_instr;

    assign opcode       = issue_instr_i[6:0];
    assign funct3       = issue_instr_i[14:12];
    assign unused_instr = ^issue_instr_i[31:15];

    // Issue-side decode and handshake gating
    always_comb begin
        supported = (opcode == 7'b0001011) &&
                    (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010);
        is_mac    = (funct3 == 3'b000);
        ops_ok    = !supported || !is_mac || (issue_rs_valid_i == 2'b11);
        full      = (count_q == CNT_W'(QUEUE_DEPTH));
        issue_ready_o     = !full && ops_ok;
        issue_accept_o    = supported;
        issue_writeback_o = supported;
        push      = issue_valid_i && issue_ready_o && supported;
    end

    // Commit targets the oldest uncommitted entry; committed entries are
    // always a contiguous run starting at the head, so ccnt_q locates it.
    always_comb begin
        cmt_idx   = head_q + ccnt_q[PTR_W-1:0];
        cmt_avail = (ccnt_q < count_q);
        cmt_ok    = commit_valid_i && cmt_avail && (q_id_q[cmt_idx] == commit_id_i);
        cmt_bad   = commit_valid_i && !cmt_ok;
        head_committed = (ccnt_q != '0);
        head_killed    = q_kill_q[head_q];
        exec_fire      = (state_q == S_EXEC) && (cnt_q == '0);
        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
        ccnt_d    = ccnt_q + CNT_W'(cmt_ok) - CNT_W'(pop);
    end

    // Queue pointers, occupancy and sticky protocol error
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ccnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            if (push) tail_q <= tail_q + PTR_W'(1);
            if (pop)  head_q <= head_q + PTR_W'(1);
            count_q <= count_d;
            ccnt_q  <= ccnt_d;
            if (cmt_bad) err_q <= 1'b1;
        end
    end

    // Queue entry payload and kill flag capture
    always_ff @(posedge clk_i) begin
        if (push) begin
            q_id_q[tail_q]  <= issue_id_i;
            q_op_q[tail_q]  <= funct3[1:0];
            q_rd_q[tail_q]  <= issue_instr_i[11:7];
            q_rs1_q[tail_q] <= issue_rs1_i;
            q_rs2_q[tail_q] <= issue_rs2_i;
        end
        if (cmt_ok) q_kill_q[cmt_idx] <= commit_kill_i;
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (head_committed && !head_killed) state_d = S_EXEC;
            S_EXEC: if (cnt_q == '0) state_d = S_RESP;
            S_RESP: if (result_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: result valid, queue pop and busy
    always_comb begin
        result_valid_o = (state_q == S_RESP);
        pop            = 1'b0;
        if (state_q == S_IDLE && head_committed && head_killed) pop = 1'b1;
        if (state_q == S_RESP && result_ready_i) pop = 1'b1;
        busy_o         = (count_q != '0) || (state_q != S_IDLE);
    end

    // Accumulator update and result value for the head instruction
    always_comb begin
        acc_next = acc_q;
        res_val  = acc_q;
        case (q_op_q[head_q])
            OP_MAC: begin
                acc_next = mac_fn(acc_q, q_rs1_q[head_q], q_rs2_q[head_q]);
                res_val  = acc_next;
            end
            OP_CLR: acc_next = '0;
            default: ;
        endcase
    end

    // Execution countdown, accumulator and held result registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            res_id_q   <= '0;
            res_data_q <= '0;
            res_rd_q   <= '0;
        end else begin
            if (state_q == S_IDLE && head_committed && !head_killed)
                cnt_q <= CYC_W'(MUL_LATENCY - 1);
            else if (state_q == S_EXEC && cnt_q != '0)
                cnt_q <= cnt_q - CYC_W'(1);
            if (exec_fire) begin
                acc_q      <= acc_next;
                res_data_q <= res_val;
                res_id_q   <= q_id_q[head_q];
                res_rd_q   <= q_rd_q[head_q];
            end
        end
    end

    assign result_id_o   = res_id_q;
    assign result_data_o = res_data_q;
    assign result_rd_o   = res_rd_q;
    assign result_we_o   = result_valid_o;
    assign err_o         = err_q;

endmodule

// File: tb/tb_cvxif_mac_unit.sv
// Scoreboard bench for cvxif_mac_unit: stimulus pushes expected results at
// commit time, a monitor pops and compares on every result handshake.
module tb_cvxif_mac_unit;

    localparam int XLEN = 64;
    localparam int IDW  = 3;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            issue_valid_i;
    logic            issue_ready_o;
    logic [31:0]     issue_instr_i;
    logic [IDW-1:0]  issue_id_i;
    logic [XLEN-1:0] issue_rs1_i, issue_rs2_i;
    logic [1:0]      issue_rs_valid_i;
    logic            issue_accept_o, issue_writeback_o;
    logic            commit_valid_i;
    logic [IDW-1:0]  commit_id_i;
    logic            commit_kill_i;
    logic            result_valid_o, result_ready_i;
    logic [IDW-1:0]  result_id_o;
    logic [XLEN-1:0] result_data_o;
    logic [4:0]      result_rd_o;
    logic            result_we_o, busy_o, err_o;

    cvxif_mac_unit #(.XLEN(64), .ID_WIDTH(3), .QUEUE_DEPTH(4), .MUL_LATENCY(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
        .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
        .issue_rs_valid_i(issue_rs_valid_i),
        .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i),
        .commit_kill_i(commit_kill_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_id_o(result_id_o), .result_data_o(result_data_o),
        .result_rd_o(result_rd_o), .result_we_o(result_we_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [IDW-1:0]  id;
        logic [XLEN-1:0] data;
        logic [4:0]      rd;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd);
        return {17'd0, f3, rd, 7'b0001011};
    endfunction

    // Result monitor: compare at every handshake
    always @(negedge clk_i) begin
        if (!rst_i && result_valid_o && result_ready_i) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got id %0d data %0h, required none", result_id_o, result_data_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res_id", 64'(result_id_o), 64'(e.id));
                chk("res_data", result_data_o, e.data);
                chk("res_rd", 64'(result_rd_o), 64'(e.rd));
                chk("res_we", 64'(result_we_o), 64'd1);
            end
        end
    end

    task automatic issue(input logic [31:0] ins, input logic [IDW-1:0] id,
                         input logic [63:0] a, input logic [63:0] b,
                         output logic acc, output logic wb);
        int n;
        issue_valid_i = 1'b1;
        issue_instr_i = ins;
        issue_id_i    = id;
        issue_rs1_i   = a;
        issue_rs2_i   = b;
        #1;
        n = 0;
        while (!issue_ready_o && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            tests++;
            fails++;
            $display("FAIL issue_timeout: id %0d never got ready, required ready within 50 cycles", id);
        end
        acc = issue_accept_o;
        wb  = issue_writeback_o;
        tick();
        issue_valid_i = 1'b0;
        issue_instr_i = 32'd0;
    endtask

    task automatic iss(input logic [2:0] f3, input logic [4:0] rd, input logic [IDW-1:0] id,
                       input logic [63:0] a, input logic [63:0] b);
        logic acc, wb;
        issue(mk(f3, rd), id, a, b, acc, wb);
        chk("accept", 64'(acc), 64'd1);
        chk("writeback", 64'(wb), 64'd1);
    endtask

    task automatic commit(input logic [IDW-1:0] id, input logic kill, input logic expect_res,
                          input logic [63:0] data, input logic [4:0] rd);
        exp_t e;
        commit_valid_i = 1'b1;
        commit_id_i    = id;
        commit_kill_i  = kill;
        if (expect_res) begin
            e.id = id; e.data = data; e.rd = rd;
            sb.push_back(e);
        end
        tick();
        commit_valid_i = 1'b0;
        commit_kill_i  = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_o || sb.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: busy %0d pending %0d, required 0 and 0", busy_o, sb.size());
        end
    endtask

    initial begin
        int n;
        logic [63:0] d0;
        logic [IDW-1:0] id0;
        logic stable, acc, wb;

        rst_i = 1'b1;
        issue_valid_i = 0; issue_instr_i = 0; issue_id_i = 0;
        issue_rs1_i = 0; issue_rs2_i = 0; issue_rs_valid_i = 2'b11;
        commit_valid_i = 0; commit_id_i = 0; commit_kill_i = 0;
        result_ready_i = 1'b1;
        tick(); tick(); tick();
        rst_i = 1'b0;
        #1;

        chk("rst_busy", 64'(busy_o), 0);
        chk("rst_valid", 64'(result_valid_o), 0);
        chk("rst_err", 64'(err_o), 0);
        chk("rst_data", result_data_o, 0);
        chk("rst_id", 64'(result_id_o), 0);
        chk("rst_rd", 64'(result_rd_o), 0);
        chk("rst_ready", 64'(issue_ready_o), 1);

        // MAC flow and latency
        iss(3'b000, 5'd10, 3'd1, 64'd3, 64'd5);
        commit(3'd1, 1'b0, 1'b1, 64'd15, 5'd10);
        n = 0;
        while (!result_valid_o && n < 20) begin
            tick();
            n++;
        end
        chk("mac_latency", 64'(n), 64'd3);
        wait_idle();
        iss(3'b010, 5'd11, 3'd2, 0, 0);
        commit(3'd2, 1'b0, 1'b1, 64'd15, 5'd11);
        wait_idle();

        // Wrap-around, clear and read back
        iss(3'b001, 5'd1, 3'd3, 0, 0);
        commit(3'd3, 1'b0, 1'b1, 64'd15, 5'd1);
        iss(3'b000, 5'd2, 3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        commit(3'd4, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2);
        wait_idle();
        iss(3'b000, 5'd2, 3'd5, 64'd1, 64'd1);
        iss(3'b001, 5'd3, 3'd6, 0, 0);
        iss(3'b010, 5'd4, 3'd7, 0, 0);
        commit(3'd5, 1'b0, 1'b1, 64'd0, 5'd2);
        commit(3'd6, 1'b0, 1'b1, 64'd0, 5'd3);
        commit(3'd7, 1'b0, 1'b1, 64'd0, 5'd4);
        wait_idle();

        // Kill leaves the accumulator untouched and yields no result
        iss(3'b000, 5'd5, 3'd0, 64'd6, 64'd7);
        commit(3'd0, 1'b0, 1'b1, 64'd42, 5'd5);
        wait_idle();
        iss(3'b000, 5'd5, 3'd2, 64'd7, 64'd7);
        iss(3'b010, 5'd6, 3'd3, 0, 0);
        commit(3'd2, 1'b1, 1'b0, 0, 0);
        commit(3'd3, 1'b0, 1'b1, 64'd42, 5'd6);
        wait_idle();
        iss(3'b010, 5'd7, 3'd4, 0, 0);
        commit(3'd4, 1'b0, 1'b1, 64'd42, 5'd7);
        wait_idle();

        // Backpressure with a full queue
        result_ready_i = 1'b0;
        iss(3'b000, 5'd8, 3'd1, 64'd2, 64'd3);
        iss(3'b010, 5'd9, 3'd2, 0, 0);
        iss(3'b010, 5'd10, 3'd3, 0, 0);
        iss(3'b010, 5'd11, 3'd4, 0, 0);
        chk("full_ready", 64'(issue_ready_o), 0);
        commit(3'd1, 1'b0, 1'b1, 64'd48, 5'd8);
        n = 0;
        while (!result_valid_o && n < 20) begin
            tick();
            n++;
        end
        d0 = result_data_o;
        id0 = result_id_o;
        chk("bp_data", d0, 64'd48);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (result_valid_o !== 1'b1 || result_data_o !== d0 || result_id_o !== id0)
                stable = 1'b0;
        end
        chk("bp_stable", 64'(stable), 1);
        chk("bp_full_ready", 64'(issue_ready_o), 0);
        result_ready_i = 1'b1;
        tick();
        chk("bp_ready_after_pop", 64'(issue_ready_o), 1);
        commit(3'd2, 1'b0, 1'b1, 64'd48, 5'd9);
        commit(3'd3, 1'b0, 1'b1, 64'd48, 5'd10);
        commit(3'd4, 1'b0, 1'b1, 64'd48, 5'd11);
        wait_idle();

        // Unsupported instruction and operand wait
        issue_valid_i = 1'b1;
        issue_instr_i = 32'h0000_0033;
        issue_id_i    = 3'd5;
        #1;
        chk("unsup_ready", 64'(issue_ready_o), 1);
        chk("unsup_accept", 64'(issue_accept_o), 0);
        chk("unsup_wb", 64'(issue_writeback_o), 0);
        tick();
        issue_valid_i = 1'b0;
        issue_instr_i = 32'd0;
        #1;
        chk("unsup_not_queued", 64'(busy_o), 0);
        issue_valid_i    = 1'b1;
        issue_instr_i    = mk(3'b000, 5'd12);
        issue_id_i       = 3'd5;
        issue_rs1_i      = 64'd1;
        issue_rs2_i      = 64'd2;
        issue_rs_valid_i = 2'b01;
        #1;
        chk("opwait_ready0", 64'(issue_ready_o), 0);
        tick();
        chk("opwait_ready1", 64'(issue_ready_o), 0);
        issue_rs_valid_i = 2'b11;
        #1;
        chk("opwait_ready2", 64'(issue_ready_o), 1);
        tick();
        issue_valid_i = 1'b0;
        issue_instr_i = 32'd0;
        commit(3'd5, 1'b0, 1'b1, 64'd50, 5'd12);
        wait_idle();

        // Commit protocol error
        iss(3'b010, 5'd13, 3'd4, 0, 0);
        commit(3'd5, 1'b0, 1'b0, 0, 0);
        chk("err_set", 64'(err_o), 1);
        for (int i = 0; i < 4; i++) tick();
        chk("err_no_exec", 64'(result_valid_o), 0);
        chk("err_still_queued", 64'(busy_o), 1);
        commit(3'd4, 1'b0, 1'b1, 64'd50, 5'd13);
        wait_idle();
        chk("err_sticky", 64'(err_o), 1);

        // Reset during EXEC
        iss(3'b000, 5'd14, 3'd6, 64'd1, 64'd1);
        commit(3'd6, 1'b0, 1'b0, 0, 0);
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("mid_rst_busy", 64'(busy_o), 0);
        chk("mid_rst_valid", 64'(result_valid_o), 0);
        chk("mid_rst_err", 64'(err_o), 0);
        iss(3'b010, 5'd15, 3'd1, 0, 0);
        commit(3'd1, 1'b0, 1'b1, 64'd0, 5'd15);
        wait_idle();

        chk("sb_drained", 64'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end

endmodule
